filter_stack_router: RTL and testbench
======================================

FILTER_STACK_ROUTER -- requirements
Module: filter_stack_router

Interface
- REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports are named clk and reset.
- REQ-002 Parameters SHALL be (name, default, meaning):
  - DATA_W, 8, pixel width.
  - N_STAGES, 4, external filter stages (2..8).
  - MAX_BPM, 255, BPM ceiling.
  - BPM_T1, 100, depth-1 upper bound.
  - BPM_T2, 140, depth-2 upper bound.
  - CNT_W, 6, in-flight counter width.
- REQ-003 Ports SHALL be (name, direction, width, meaning):
  - clk, in, 1, clock.
  - reset, in, 1, sync active-high reset.
  - pixel_in, in, DATA_W, source pixel.
  - pixel_in_valid, in, 1, pixel present.
  - pixel_in_sof, in, 1, first pixel of frame.
  - pixel_in_ready, out, 1, pixel accepted when valid&ready.
  - BPM_estimate, in, $clog2(MAX_BPM+1), tempo.
  - filter_enable, in, 1, 0 forces bypass.
  - stage_in_data, out, DATA_W, feed to stage 0.
  - stage_in_valid, out, 1, feed valid.
  - tap_data, in, N_STAGES*DATA_W, output of stage k at slice k.
  - tap_valid, in, N_STAGES, stage k output valid.
  - pixel_out, out, DATA_W, routed pixel.
  - pixel_out_valid, out, 1, output valid.
  - pixel_out_sof, out, 1, first output of frame.
  - depth, out, $clog2(N_STAGES+1), active stage count.
  - err_underflow, out, 1, sticky tap-without-pixel flag.

Function
- REQ-004 Depth request SHALL be:
  - 0 if filter_enable=0.
  - else 1 if BPM_estimate<BPM_T1.
  - else 2 if BPM_estimate<BPM_T2.
  - else N_STAGES.
- REQ-005 Depth SHALL change only at a frame boundary inside state SWITCH, never mid-frame.
- REQ-006 States SHALL be IDLE, RUN, DRAIN, SWITCH.
- REQ-007 IDLE SHALL hold ready=1, discard every non-SOF pixel, and on an SOF pixel being valid drop ready combinationally (pixel not accepted) and go to DRAIN.
- REQ-008 RUN SHALL hold ready=1 while inflight<2^CNT_W-1, else ready=0.
- REQ-009 A valid SOF pixel in RUN SHALL not be accepted (ready=0 that cycle) and SHALL move the FSM to DRAIN.
- REQ-010 DRAIN SHALL hold ready=0 and go to SWITCH on the first cycle inflight==0.
- REQ-011 SWITCH SHALL last one cycle with ready=0, load depth from REQ-004 sampled that cycle, arm sof_pending, and go to RUN.
- REQ-012 Accepting a pixel with depth>=1 SHALL drive stage_in_data=pixel_in and stage_in_valid=1 in the same cycle, combinationally.
- REQ-013 Accepting a pixel with depth>=1 SHALL increment inflight.
- REQ-014 With depth=0, stage_in_valid SHALL be 0 and inflight SHALL stay 0.
- REQ-015 The selected tap SHALL be index depth-1; valids on all other taps SHALL be ignored.
- REQ-016 A selected tap_valid SHALL decrement inflight.
- REQ-017 An accept and a selected tap_valid in the same cycle SHALL leave inflight unchanged.
- REQ-018 A selected tap_valid with inflight==0 SHALL not decrement, SHALL produce no output, and SHALL set err_underflow until reset.
- REQ-019 Output SHALL be registered, with pixel_out_valid asserted exactly 1 cycle after the event:
  - depth=0: the cycle after pixel accept, carrying pixel_in.
  - depth>=1: the cycle after selected tap_valid, carrying that tap slice.
- REQ-020 pixel_out_sof SHALL be 1 on the first output after SWITCH, then clear sof_pending.
- REQ-021 pixel_out_sof SHALL be 0 whenever pixel_out_valid=0.
- REQ-022 pixel_out SHALL hold its last value when pixel_out_valid=0.
- REQ-023 Ordering SHALL be preserved: no output of frame N+1 precedes the last output of frame N.

Reset
- REQ-024 While reset=1 at a clock edge, the block SHALL set:
  - state=IDLE, depth=0, inflight=0, sof_pending=0, err_underflow=0.
  - pixel_out=0, pixel_out_valid=0, pixel_out_sof=0.
- REQ-025 While reset=1, pixel_in_ready and stage_in_valid SHALL be 0.
- REQ-026 Reset mid-frame or mid-DRAIN SHALL abandon in-flight pixels; taps arriving after reset SHALL set err_underflow.

Verification
- REQ-027 Bypass: filter_enable=0, SOF then pixels 0x10,0x20,0x30 → after SWITCH depth=0; outputs 0x10(sof=1),0x20,0x30, each 1 cycle after accept.
- REQ-028 BPM routing: BPM=90/120/200 on successive frames → depth 1/2/4 (N_STAGES=4); outputs come only from tap 0/1/3 respectively.
- REQ-029 Drain: depth 4, 5 pixels in flight, SOF with BPM=90 → ready=0 until the 5th tap[3] valid; then one SWITCH cycle, depth=1, SOF pixel accepted next cycle.
- REQ-030 Simultaneous: accept and tap_valid every cycle for 20 cycles → inflight constant, ready never drops.
- REQ-031 Saturation: CNT_W=3, taps silent → ready drops after 7 accepts and returns the cycle after one tap_valid.
- REQ-032 Fault and reset: tap_valid with inflight=0 → no output, err_underflow=1; reset → all outputs 0, err_underflow=0, state IDLE.

Source files
------------

// File: rtl/filter_stack_router.sv
// filter_stack_router
// Routes a pixel stream through a configurable-depth chain of external filter
// stages. The stage count is chosen from a tempo (BPM) estimate, and it is only
// changed between frames, once every pixel of the old frame has come back out.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   pixel_in*           source pixel stream (valid/ready handshake, sof marker)
//   BPM_estimate        tempo used to pick the stage count
//   filter_enable       0 forces bypass (no stages)
//   stage_in_*          feed into external stage 0 (combinational from pixel_in)
//   tap_data/tap_valid  outputs of every external stage, stage k at slice k
//   pixel_out*          registered routed output stream
//   depth               number of active stages for the current frame
//   err_underflow       sticky: selected tap fired with nothing in flight
module filter_stack_router #(
   parameter int DATA_W   = 8,
   parameter int N_STAGES = 4,
   parameter int MAX_BPM  = 255,
   parameter int BPM_T1   = 100,
   parameter int BPM_T2   = 140,
   parameter int CNT_W    = 6
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [DATA_W-1:0]               pixel_in,
   input  logic                            pixel_in_valid,
   input  logic                            pixel_in_sof,
   output logic                            pixel_in_ready,
   input  logic [$clog2(MAX_BPM+1)-1:0]    BPM_estimate,
   input  logic                            filter_enable,
   output logic [DATA_W-1:0]               stage_in_data,
   output logic                            stage_in_valid,
   input  logic [N_STAGES*DATA_W-1:0]      tap_data,
   input  logic [N_STAGES-1:0]             tap_valid,
   output logic [DATA_W-1:0]               pixel_out,
   output logic                            pixel_out_valid,
   output logic                            pixel_out_sof,
   output logic [$clog2(N_STAGES+1)-1:0]   depth,
   output logic                            err_underflow
);

   localparam int BPM_W   = $clog2(MAX_BPM+1);
   localparam int DEPTH_W = $clog2(N_STAGES+1);
   localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      SWITCH = 2'd3
   } state_t;

   state_t              state_r;
   logic [DEPTH_W-1:0]  depth_r;
   logic [CNT_W-1:0]    inflight_r;
   logic                frame_start_r;   // next pixel is the SOF that opened this frame
   logic                sof_pending_r;
   logic                err_r;
   logic [DATA_W-1:0]   pixel_out_r;
   logic                pixel_out_valid_r;
   logic                pixel_out_sof_r;

   logic [DEPTH_W-1:0]  depth_req_s;
   logic                sel_valid_s;
   logic [DATA_W-1:0]   sel_data_s;
   logic                ready_s;
   logic                sof_s;
   logic                accept_s;
   logic                route_s;
   logic                feed_s;
   logic                bypass_s;
   logic                take_s;
   logic                under_s;

   assign sof_s    = pixel_in_valid && pixel_in_sof;
   assign accept_s = pixel_in_valid && ready_s;
   // Pixels accepted in IDLE are discarded; only RUN forwards them.
   assign route_s  = accept_s && (state_r == RUN);
   assign feed_s   = route_s && (depth_r != DEPTH_ZERO);
   assign bypass_s = route_s && (depth_r == DEPTH_ZERO);
   assign take_s   = sel_valid_s && (inflight_r != CNT_ZERO);
   assign under_s  = sel_valid_s && (inflight_r == CNT_ZERO);

   assign pixel_in_ready  = ready_s;
   assign stage_in_data   = pixel_in;
   assign stage_in_valid  = feed_s;
   assign pixel_out       = pixel_out_r;
   assign pixel_out_valid = pixel_out_valid_r;
   assign pixel_out_sof   = pixel_out_sof_r;
   assign depth           = depth_r;
   assign err_underflow   = err_r;

   // Stage count requested by the current tempo and enable.
   always_comb begin
      depth_req_s = DEPTH_ZERO;
      if (!filter_enable) begin
         depth_req_s = DEPTH_ZERO;
      end else if (BPM_estimate < BPM_W'(BPM_T1)) begin
         depth_req_s = DEPTH_W'(32'd1);
      end else if (BPM_estimate < BPM_W'(BPM_T2)) begin
         depth_req_s = DEPTH_W'(32'd2);
      end else begin
         depth_req_s = DEPTH_W'(N_STAGES);
      end
   end

   // Select tap depth-1; depth 0 selects nothing.
   always_comb begin
      sel_valid_s = 1'b0;
      sel_data_s  = {DATA_W{1'b0}};
      for (int k = 0; k < N_STAGES; k++) begin
         sel_valid_s = sel_valid_s | ((depth_r == DEPTH_W'(k + 1)) & tap_valid[k]);
         sel_data_s  = sel_data_s
                     | ({DATA_W{depth_r == DEPTH_W'(k + 1)}} & tap_data[k*DATA_W +: DATA_W]);
      end
   end

   // Input handshake. A new-frame SOF is held off until the pipe has drained,
   // except the SOF that is re-presented right after SWITCH.
   always_comb begin
      ready_s = 1'b0;
      if (reset) begin
         ready_s = 1'b0;
      end else begin
         case (state_r)
            IDLE:    ready_s = !sof_s;
            RUN:     ready_s = (inflight_r != CNT_MAX) && !(sof_s && !frame_start_r);
            DRAIN:   ready_s = 1'b0;
            SWITCH:  ready_s = 1'b0;
            default: ready_s = 1'b0;
         endcase
      end
   end

   // Frame FSM: depth is only reloaded in SWITCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         depth_r       <= DEPTH_ZERO;
         frame_start_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (sof_s) state_r <= DRAIN;
            end
            RUN: begin
               if (sof_s && !frame_start_r) state_r <= DRAIN;
               if (accept_s) frame_start_r <= 1'b0;
            end
            DRAIN: begin
               if (inflight_r == CNT_ZERO) state_r <= SWITCH;
            end
            SWITCH: begin
               depth_r       <= depth_req_s;
               frame_start_r <= 1'b1;
               state_r       <= RUN;
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // In-flight counter: feed and take in the same cycle cancel out.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_r <= CNT_ZERO;
      end else begin
         case ({feed_s, take_s})
            2'b10:   inflight_r <= inflight_r + CNT_ONE;
            2'b01:   inflight_r <= inflight_r - CNT_ONE;
            default: inflight_r <= inflight_r;
         endcase
      end
   end

   // Sticky underflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_r <= 1'b0;
      end else if (under_s) begin
         err_r <= 1'b1;
      end
   end

   // Registered output stage and first-output-of-frame marker.
   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_out_r       <= {DATA_W{1'b0}};
         pixel_out_valid_r <= 1'b0;
         pixel_out_sof_r   <= 1'b0;
         sof_pending_r     <= 1'b0;
      end else begin
         if (bypass_s) begin
            pixel_out_r       <= pixel_in;
            pixel_out_valid_r <= 1'b1;
            pixel_out_sof_r   <= sof_pending_r;
         end else if (take_s) begin
            pixel_out_r       <= sel_data_s;
            pixel_out_valid_r <= 1'b1;
            pixel_out_sof_r   <= sof_pending_r;
         end else begin
            pixel_out_valid_r <= 1'b0;
            pixel_out_sof_r   <= 1'b0;
         end
         if (state_r == SWITCH) begin
            sof_pending_r <= 1'b1;
         end else if (bypass_s || take_s) begin
            sof_pending_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_filter_stack_router.sv
// Testbench for filter_stack_router (N_STAGES=4, CNT_W=3). Expected output
// pixels go into exp_q when stimulus is driven; a monitor records every DUT
// output into obs_q, and the two streams are compared at the end.
module tb_filter_stack_router;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  pixel_in = 8'h00;
   logic        pixel_in_valid = 1'b0;
   logic        pixel_in_sof = 1'b0;
   logic        pixel_in_ready;
   logic [7:0]  BPM_estimate = 8'd0;
   logic        filter_enable = 1'b0;
   logic [7:0]  stage_in_data;
   logic        stage_in_valid;
   logic [31:0] tap_data = 32'h0;
   logic [3:0]  tap_valid = 4'h0;
   logic [7:0]  pixel_out;
   logic        pixel_out_valid;
   logic        pixel_out_sof;
   logic [2:0]  depth;
   logic        err_underflow;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int idle_viol = 0;
   logic [7:0] last_out = 8'h00;

   typedef struct packed { logic [7:0] d; logic s; logic [31:0] c; } ent_t;
   ent_t exp_q[$];
   ent_t obs_q[$];

   filter_stack_router #(.DATA_W(8), .N_STAGES(4), .MAX_BPM(255),
                         .BPM_T1(100), .BPM_T2(140), .CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
      .pixel_in_sof(pixel_in_sof), .pixel_in_ready(pixel_in_ready),
      .BPM_estimate(BPM_estimate), .filter_enable(filter_enable),
      .stage_in_data(stage_in_data), .stage_in_valid(stage_in_valid),
      .tap_data(tap_data), .tap_valid(tap_valid),
      .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid),
      .pixel_out_sof(pixel_out_sof), .depth(depth),
      .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   initial begin : cycle_counter
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (reset) begin
            last_out = 8'h00;
         end else if (pixel_out_valid) begin
            obs_q.push_back('{pixel_out, pixel_out_sof, 32'(cyc)});
            last_out = pixel_out;
         end else if (pixel_out_sof !== 1'b0 || pixel_out !== last_out) begin
            idle_viol++;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one pixel, wait (bounded) for ready, let it be accepted.
   task automatic send(input logic [7:0] d, input logic s, input logic byp,
                       input logic exp_sof, output int waited);
      pixel_in = d;
      pixel_in_sof = s;
      pixel_in_valid = 1'b1;
      waited = 0;
      #1;
      while (pixel_in_ready !== 1'b1 && waited < 20) begin
         tick();
         #1;
         waited++;
      end
      tests_run++;
      if (pixel_in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL send_timeout: ready got %b expected 1 for pixel %h", pixel_in_ready, d);
      end else begin
         if (byp) exp_q.push_back('{d, exp_sof, 32'(cyc + 1)});
         if (stage_in_valid !== !byp || (!byp && stage_in_data !== d)) begin
            tests_failed++;
            $display("FAIL stage_feed: got valid=%b data=%h expected valid=%b data=%h",
                     stage_in_valid, stage_in_data, !byp, d);
         end
      end
      tick();
      pixel_in_valid = 1'b0;
      pixel_in_sof = 1'b0;
   endtask

   // One cycle of tap k valid; push the expected output if one should appear.
   task automatic tap(input int k, input logic [7:0] d, input logic push, input logic exp_sof);
      tap_valid = 4'h0;
      tap_valid[k] = 1'b1;
      tap_data[k*8 +: 8] = d;
      if (push) exp_q.push_back('{d, exp_sof, 32'(cyc + 1)});
      tick();
      tap_valid = 4'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      pixel_in_valid = 1'b1;
      pixel_in_sof = 1'b1;
      tick();
      tick();
      #1;
      tests_run++;
      if (pixel_in_ready !== 1'b0 || stage_in_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ready: got ready=%b stage_valid=%b expected 0 0", pixel_in_ready, stage_in_valid);
      end
      tests_run++;
      if (pixel_out !== 8'h00 || pixel_out_valid !== 1'b0 || pixel_out_sof !== 1'b0
          || depth !== 3'd0 || err_underflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: got out=%h v=%b sof=%b depth=%0d err=%b expected 00 0 0 0 0",
                  pixel_out, pixel_out_valid, pixel_out_sof, depth, err_underflow);
      end
      reset = 1'b0;
      pixel_in_valid = 1'b0;
      pixel_in_sof = 1'b0;
      tick();
      // IDLE accepts and discards a non-SOF pixel
      pixel_in = 8'h99;
      pixel_in_valid = 1'b1;
      #1;
      tests_run++;
      if (pixel_in_ready !== 1'b1 || stage_in_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_discard: got ready=%b stage_valid=%b expected 1 0", pixel_in_ready, stage_in_valid);
      end
      tick();
      pixel_in_valid = 1'b0;
   endtask

   task automatic test_bypass();
      int w;
      filter_enable = 1'b0;
      BPM_estimate = 8'd200;
      send(8'h10, 1'b1, 1'b1, 1'b1, w);
      tests_run++;
      if (w != 3) begin
         tests_failed++;
         $display("FAIL bypass_sof_wait: got %0d cycles expected 3", w);
      end
      tests_run++;
      if (depth !== 3'd0) begin
         tests_failed++;
         $display("FAIL bypass_depth: got %0d expected 0", depth);
      end
      send(8'h20, 1'b0, 1'b1, 1'b0, w);
      send(8'h30, 1'b0, 1'b1, 1'b0, w);
      tests_run++;
      if (w != 0) begin
         tests_failed++;
         $display("FAIL bypass_wait: got %0d cycles expected 0", w);
      end
   endtask

   task automatic test_bpm_routing();
      int bpm_t[7] = '{90, 120, 200, 99, 100, 139, 140};
      int dep_t[7] = '{1, 2, 4, 1, 2, 2, 4};
      int w;
      int sel;
      logic [7:0] base;
      filter_enable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         BPM_estimate = 8'(bpm_t[i]);
         base = 8'(8'h40 + 16 * i);
         send(base, 1'b1, 1'b0, 1'b0, w);
         tests_run++;
         if (w != 3 || depth !== 3'(dep_t[i])) begin
            tests_failed++;
            $display("FAIL route_depth bpm=%0d: got depth=%0d wait=%0d expected depth=%0d wait=3",
                     bpm_t[i], depth, w, dep_t[i]);
         end
         send(8'(base + 8'd1), 1'b0, 1'b0, 1'b0, w);
         sel = dep_t[i] - 1;
         // every unselected tap fires: must be ignored
         tap_valid = ~(4'b0001 << sel);
         tap_data = 32'hEEEE_EEEE;
         tick();
         tap_valid = 4'h0;
         tap(sel, base ^ 8'hFF, 1'b1, 1'b1);
         tap(sel, 8'(base + 8'd1) ^ 8'hFF, 1'b1, 1'b0);
         tests_run++;
         if (err_underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL route_err bpm=%0d: got %b expected 0", bpm_t[i], err_underflow);
         end
      end
   endtask

   task automatic test_drain();
      int w;
      filter_enable = 1'b1;
      BPM_estimate = 8'd200;
      send(8'hB0, 1'b1, 1'b0, 1'b0, w);
      for (int j = 1; j < 5; j++) send(8'(8'hB0 + j), 1'b0, 1'b0, 1'b0, w);
      tests_run++;
      if (depth !== 3'd4) begin
         tests_failed++;
         $display("FAIL drain_depth4: got %0d expected 4", depth);
      end
      BPM_estimate = 8'd90;
      pixel_in = 8'h77;
      pixel_in_sof = 1'b1;
      pixel_in_valid = 1'b1;
      #1;
      tests_run++;
      if (pixel_in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain_sof_block: got ready=%b expected 0", pixel_in_ready);
      end
      tick();
      for (int j = 0; j < 5; j++) begin
         tap_valid = 4'b1000;
         tap_data[31:24] = 8'(8'hC0 + j);
         exp_q.push_back('{8'(8'hC0 + j), (j == 0), 32'(cyc + 1)});
         #1;
         tests_run++;
         if (pixel_in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_ready tap%0d: got %b expected 0", j, pixel_in_ready);
         end
         tick();
         tap_valid = 4'h0;
      end
      send(8'h77, 1'b1, 1'b0, 1'b0, w);
      tests_run++;
      if (w != 2 || depth !== 3'd1) begin
         tests_failed++;
         $display("FAIL drain_switch: got wait=%0d depth=%0d expected wait=2 depth=1", w, depth);
      end
   endtask

   task automatic test_back_to_back();
      int w;
      send(8'h78, 1'b0, 1'b0, 1'b0, w);
      for (int j = 0; j < 20; j++) begin
         pixel_in = 8'(8'h80 + j);
         pixel_in_sof = 1'b0;
         pixel_in_valid = 1'b1;
         tap_valid = 4'b0001;
         tap_data[7:0] = 8'(8'h90 + j);
         exp_q.push_back('{8'(8'h90 + j), (j == 0), 32'(cyc + 1)});
         #1;
         tests_run++;
         if (pixel_in_ready !== 1'b1 || stage_in_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready cycle %0d: got ready=%b stage_valid=%b expected 1 1",
                     j, pixel_in_ready, stage_in_valid);
         end
         tick();
      end
      pixel_in_valid = 1'b0;
      tap_valid = 4'h0;
      // inflight must still be 2: exactly two taps produce output
      tap(0, 8'hA1, 1'b1, 1'b0);
      tap(0, 8'hA2, 1'b1, 1'b0);
      tests_run++;
      if (err_underflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_err: got %b expected 0", err_underflow);
      end
   endtask

   task automatic test_saturation();
      int w;
      BPM_estimate = 8'd90;
      send(8'hD0, 1'b1, 1'b0, 1'b0, w);
      for (int j = 1; j < 7; j++) begin
         send(8'(8'hD0 + j), 1'b0, 1'b0, 1'b0, w);
         tests_run++;
         if (w != 0) begin
            tests_failed++;
            $display("FAIL sat_early_block accept %0d: got wait=%0d expected 0", j, w);
         end
      end
      pixel_in = 8'hD7;
      pixel_in_valid = 1'b1;
      for (int j = 0; j < 2; j++) begin
         #1;
         tests_run++;
         if (pixel_in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_full cycle %0d: got ready=%b expected 0", j, pixel_in_ready);
         end
         tick();
      end
      tap_valid = 4'b0001;
      tap_data[7:0] = 8'hE0;
      exp_q.push_back('{8'hE0, 1'b1, 32'(cyc + 1)});
      tick();
      tap_valid = 4'h0;
      #1;
      tests_run++;
      if (pixel_in_ready !== 1'b1 || stage_in_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL sat_release: got ready=%b stage_valid=%b expected 1 1", pixel_in_ready, stage_in_valid);
      end
      tick();
      pixel_in_valid = 1'b0;
      for (int j = 1; j < 8; j++) tap(0, 8'(8'hE0 + j), 1'b1, 1'b0);
   endtask

   task automatic test_fault_reset();
      int w;
      tap(0, 8'h55, 1'b0, 1'b0);
      #1;
      tests_run++;
      if (err_underflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL underflow_flag: got %b expected 1", err_underflow);
      end
      send(8'h61, 1'b0, 1'b0, 1'b0, w);
      reset = 1'b1;
      pixel_in = 8'h66;
      pixel_in_valid = 1'b1;
      #1;
      tests_run++;
      if (pixel_in_ready !== 1'b0 || stage_in_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_ready: got ready=%b stage_valid=%b expected 0 0", pixel_in_ready, stage_in_valid);
      end
      tick();
      tests_run++;
      if (pixel_out !== 8'h00 || pixel_out_valid !== 1'b0 || pixel_out_sof !== 1'b0
          || depth !== 3'd0 || err_underflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_state: got out=%h v=%b sof=%b depth=%0d err=%b expected 00 0 0 0 0",
                  pixel_out, pixel_out_valid, pixel_out_sof, depth, err_underflow);
      end
      reset = 1'b0;
      pixel_in_valid = 1'b0;
      tick();
      send(8'h62, 1'b1, 1'b0, 1'b0, w);
      tests_run++;
      if (w != 3 || depth !== 3'd1) begin
         tests_failed++;
         $display("FAIL postreset_frame: got wait=%0d depth=%0d expected 3 1", w, depth);
      end
      tap(0, 8'h63, 1'b1, 1'b1);
      tap(0, 8'h64, 1'b0, 1'b0);
      #1;
      tests_run++;
      if (err_underflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL stale_tap_err: got %b expected 1", err_underflow);
      end
   endtask

   task automatic test_output_stream();
      int n;
      ent_t e;
      ent_t o;
      tick();
      tick();
      tests_run++;
      if (obs_q.size() != exp_q.size()) begin
         tests_failed++;
         $display("FAIL out_count: got %0d outputs expected %0d", obs_q.size(), exp_q.size());
      end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         tests_run++;
         if (o.d !== e.d || o.s !== e.s || o.c !== e.c) begin
            tests_failed++;
            $display("FAIL out_%0d: got data=%h sof=%b cyc=%0d expected data=%h sof=%b cyc=%0d",
                     i, o.d, o.s, o.c, e.d, e.s, e.c);
         end
      end
      tests_run++;
      if (idle_viol != 0) begin
         tests_failed++;
         $display("FAIL idle_hold: got %0d idle cycles with sof set or data changed expected 0", idle_viol);
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_bpm_routing();
      test_drain();
      test_back_to_back();
      test_saturation();
      test_fault_reset();
      test_output_stream();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
